// File: rtl/pulse_train_generator_if.sv
// rtl/pulse_train_generator_if.sv - request/waveform bundle for the pulse train generator
interface pulse_train_generator_if #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
);
    logic             start;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] num_pulses;
    logic             dout;
    logic             edge_out;
    logic             busy;
    logic             done;

    modport master (
        output start, high_len, low_len, num_pulses,
        input  dout, edge_out, busy, done
    );

    modport slave (
        input  start, high_len, low_len, num_pulses,
        output dout, edge_out, busy, done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// rtl/pulse_train_generator.sv - registered programmable pulse train with edge and done markers
module pulse_train_generator #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_train_generator_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [NUM_W-1:0] pulses, pulses_n;
    logic [CNT_W-1:0] h_lat, h_lat_n;
    logic [CNT_W-1:0] l_lat, l_lat_n;
    logic             dout_q, dout_n;
    logic             edge_q, edge_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic [CNT_W-1:0] h_in, l_in;

    assign h_in = (bus.high_len == '0) ? CNT_W'(1) : bus.high_len;
    assign l_in = (bus.low_len  == '0) ? CNT_W'(1) : bus.low_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            pulses <= '0;
            h_lat  <= '0;
            l_lat  <= '0;
            dout_q <= 1'b0;
            edge_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pulses <= pulses_n;
            h_lat  <= h_lat_n;
            l_lat  <= l_lat_n;
            dout_q <= dout_n;
            edge_q <= edge_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    // cnt holds the cycles left in the current phase after this one; pulses holds pulses left after this one
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pulses_n = pulses;
        h_lat_n  = h_lat;
        l_lat_n  = l_lat;
        dout_n   = 1'b0;
        edge_n   = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_pulses != '0) begin
                        state_n  = HIGH;
                        h_lat_n  = h_in;
                        l_lat_n  = l_in;
                        cnt_n    = h_in - CNT_W'(1);
                        pulses_n = bus.num_pulses - NUM_W'(1);
                        dout_n   = 1'b1;
                        edge_n   = 1'b1;
                        busy_n   = 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            HIGH: begin
                busy_n = 1'b1;
                if (cnt == '0) begin
                    state_n = LOW;
                    cnt_n   = l_lat - CNT_W'(1);
                end else begin
                    cnt_n  = cnt - CNT_W'(1);
                    dout_n = 1'b1;
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    cnt_n  = cnt - CNT_W'(1);
                    busy_n = 1'b1;
                end else if (pulses != '0) begin
                    state_n  = HIGH;
                    cnt_n    = h_lat - CNT_W'(1);
                    pulses_n = pulses - NUM_W'(1);
                    dout_n   = 1'b1;
                    edge_n   = 1'b1;
                    busy_n   = 1'b1;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dout     = dout_q;
    assign bus.edge_out = edge_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb/tb_pulse_train_generator.sv - table-driven check of pulse_train_generator waveforms
module tb_pulse_train_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pulse_train_generator_if #(.CNT_W(8), .NUM_W(8)) bus ();

    pulse_train_generator #(.CNT_W(8), .NUM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // One row per clock cycle: inputs driven during the cycle, outputs expected in that cycle
    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] n;
        logic [3:0] exp;   // {dout, edge_out, busy, done}
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input string name, input logic r, input logic s,
                       input logic [7:0] h, input logic [7:0] l, input logic [7:0] n,
                       input logic [3:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.start = s; v.h = h; v.l = l; v.n = n; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    int done_cyc;
    int highs;
    int edges;

    initial begin
        bus.start = 1'b0; bus.high_len = '0; bus.low_len = '0; bus.num_pulses = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        add("reset", 0, 0, 0, 0, 0, 4'b0000);
        // Basic train H=2 L=3 N=3
        add("basic", 0, 1, 2, 3, 3, 4'b0000);
        add("basic", 0, 0, 2, 3, 3, 4'b1110);
        add("basic", 0, 0, 2, 3, 3, 4'b1010);
        for (int i = 0; i < 3; i++) add("basic", 0, 0, 2, 3, 3, 4'b0010);
        add("basic", 0, 0, 2, 3, 3, 4'b1110);
        add("basic", 0, 0, 2, 3, 3, 4'b1010);
        for (int i = 0; i < 3; i++) add("basic", 0, 0, 2, 3, 3, 4'b0010);
        add("basic", 0, 0, 2, 3, 3, 4'b1110);
        add("basic", 0, 0, 2, 3, 3, 4'b1010);
        for (int i = 0; i < 3; i++) add("basic", 0, 0, 2, 3, 3, 4'b0010);
        add("basic", 0, 0, 2, 3, 3, 4'b0001);
        // Zero clamping H=0 L=0 N=4
        add("clamp", 0, 1, 0, 0, 4, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            add("clamp", 0, 0, 0, 0, 4, 4'b1110);
            add("clamp", 0, 0, 0, 0, 4, 4'b0010);
        end
        add("clamp", 0, 0, 0, 0, 4, 4'b0001);
        // Empty train
        add("empty", 0, 1, 3, 3, 0, 4'b0000);
        add("empty", 0, 0, 3, 3, 0, 4'b0001);
        // Busy protection H=4 L=4 N=2, restart attempt at cycle 5
        add("busy", 0, 1, 4, 4, 2, 4'b0000);
        add("busy", 0, 0, 4, 4, 2, 4'b1110);
        for (int i = 0; i < 3; i++) add("busy", 0, 0, 4, 4, 2, 4'b1010);
        add("busy", 0, 1, 1, 1, 7, 4'b0010);
        for (int i = 0; i < 3; i++) add("busy", 0, 0, 1, 1, 7, 4'b0010);
        add("busy", 0, 0, 1, 1, 7, 4'b1110);
        for (int i = 0; i < 3; i++) add("busy", 0, 0, 1, 1, 7, 4'b1010);
        for (int i = 0; i < 4; i++) add("busy", 0, 0, 1, 1, 7, 4'b0010);
        add("busy", 0, 0, 1, 1, 7, 4'b0001);
        add("busy", 0, 0, 1, 1, 7, 4'b0000);
        // Back-to-back H=1 L=1 N=1 with start held
        add("b2b", 0, 1, 1, 1, 1, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            add("b2b", 0, 1, 1, 1, 1, 4'b1110);
            add("b2b", 0, 1, 1, 1, 1, 4'b0010);
            add("b2b", 0, 1, 1, 1, 1, 4'b0001);
        end
        add("b2b", 0, 0, 1, 1, 1, 4'b1110);
        add("b2b", 0, 0, 1, 1, 1, 4'b0010);
        add("b2b", 0, 0, 1, 1, 1, 4'b0001);
        add("b2b", 0, 0, 1, 1, 1, 4'b0000);
        // Reset mid-train H=5 L=5 N=3, rst at cycle 8, restart at cycle 12
        add("rst_mid", 0, 1, 5, 5, 3, 4'b0000);
        add("rst_mid", 0, 0, 5, 5, 3, 4'b1110);
        for (int i = 0; i < 4; i++) add("rst_mid", 0, 0, 5, 5, 3, 4'b1010);
        for (int i = 0; i < 2; i++) add("rst_mid", 0, 0, 5, 5, 3, 4'b0010);
        add("rst_mid", 1, 0, 5, 5, 3, 4'b0010);
        for (int i = 0; i < 3; i++) add("rst_mid", 0, 0, 5, 5, 3, 4'b0000);
        add("rst_mid", 0, 1, 1, 1, 1, 4'b0000);
        add("rst_mid", 0, 0, 1, 1, 1, 4'b1110);
        add("rst_mid", 0, 0, 1, 1, 1, 4'b0010);
        add("rst_mid", 0, 0, 1, 1, 1, 4'b0001);
        add("rst_mid", 0, 0, 1, 1, 1, 4'b0000);
        // rst together with start: rst wins
        add("rst_start", 1, 1, 2, 2, 2, 4'b0000);
        add("rst_start", 0, 0, 2, 2, 2, 4'b0000);
        add("rst_start", 0, 0, 2, 2, 2, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            check(vecs[i].name, i, {bus.dout, bus.edge_out, bus.busy, bus.done}, vecs[i].exp);
            rst            = vecs[i].rst;
            bus.start      = vecs[i].start;
            bus.high_len   = vecs[i].h;
            bus.low_len    = vecs[i].l;
            bus.num_pulses = vecs[i].n;
            @(negedge clk);
        end

        // Maximum high width H=255 L=1 N=1: done expected at cycle 257
        rst = 1'b0;
        bus.start = 1'b1; bus.high_len = 8'd255; bus.low_len = 8'd1; bus.num_pulses = 8'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.high_len = 8'd3;
        done_cyc = -1; highs = 0; edges = 0;
        for (int c = 1; c <= 400; c++) begin
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            if (bus.dout) highs++;
            if (bus.edge_out) edges++;
            @(negedge clk);
        end
        check("max_done_cycle", 0, done_cyc, 257);
        check("max_high_width", 0, highs, 255);
        check("max_edges", 0, edges, 1);
        @(negedge clk);
        check("max_idle", 0, {bus.dout, bus.edge_out, bus.busy, bus.done}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
Transmit-side counterpart to the edge detection logic. On a start request it drives a clean, fully registered pulse train on dout: a programmable number of pulses, each with programmable high and low widths. It also emits a one-cycle marker on every rising edge it produces and a completion pulse at the end. Used to stimulate or signal downstream edge-sensitive logic within the same clock domain.

Parameters:
CNT_W, 8, width of high_len / low_len and the internal phase counter
NUM_W, 8, width of num_pulses and the internal pulse counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
high_len  input  CNT_W  cycles dout is high per pulse; 0 treated as 1
low_len  input  CNT_W  cycles dout is low after each pulse; 0 treated as 1
num_pulses  input  NUM_W  pulses per request; 0 = empty train
dout  output  1  generated waveform, registered
edge_out  output  1  one-cycle pulse, high in the first high cycle of each pulse, registered
busy  output  1  high while a train is in progress (HIGH or LOW state)
done  output  1  one-cycle pulse on completion, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: dout=0, edge_out=0, busy=0, done=0, state=IDLE, all counters 0.
- FSM states: IDLE, HIGH, LOW.
- IDLE, start=1, num_pulses>0:
  - Latch high_len, low_len and num_pulses, clamping zero lengths to 1.
  - Go to HIGH. Next cycle: dout=1, edge_out=1, busy=1.
- IDLE, start=1, num_pulses=0:
  - Stay in IDLE. Next cycle: done=1, dout=0, busy=0.
- HIGH:
  - dout=1 for exactly H latched cycles, then LOW.
  - edge_out=1 only in the first HIGH cycle of each pulse.
- LOW:
  - dout=0 for exactly L latched cycles.
  - If pulses remain, go to HIGH (new rising edge, edge_out=1).
  - Otherwise go to IDLE.
- Completion: the first cycle back in IDLE after the final LOW phase has done=1, busy=0, dout=0.
  - Pulse k (0-based) rises at cycle 1+k*(H+L) after the start sample.
  - done occurs at cycle 1+N*(H+L).
- Latched values are immune to input changes mid-train.
- start while busy: ignored, no queuing.
- start high in the done cycle: accepted, because the FSM is in IDLE. The new train begins the following cycle, so trains can run back-to-back.
- start held high continuously: trains repeat back-to-back. Each train starts in the cycle after the previous done.
- Width rules:
  - H and L range from 1 to 2^CNT_W-1.
  - N ranges from 1 to 2^NUM_W-1.
  - Counters never wrap within a train.
- rst mid-train: on the next edge, dout=0, busy=0, edge_out=0. No done is issued and the FSM goes to IDLE.
- rst together with start: rst wins.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Basic train: H=2, L=3, N=3, start pulsed at cycle 0.
  - dout high in cycles 1-2, 6-7 and 11-12, low otherwise.
  - edge_out high at cycles 1, 6 and 11.
  - busy high in cycles 1-15; done at cycle 16.
- Zero clamping: H=0, L=0, N=4.
  - dout toggles 1,0,1,0,1,0,1,0 over cycles 1-8.
  - 4 edge_out pulses; done at cycle 9.
- Empty train: N=0, start pulsed.
  - done=1 at cycle 1; dout and busy stay 0; no edge_out.
- Busy protection: H=4, L=4, N=2; start repulsed at cycle 5 with N=7 and the inputs changed.
  - Exactly 2 pulses of width 4; done at cycle 17.
- Back-to-back: H=1, L=1, N=1 with start held high.
  - Pattern dout=1,0, then done cycle, repeating.
  - edge_out at cycles 1, 4, 7, ...; done at cycles 3, 6, 9, ...
- Reset mid-operation: H=5, L=5, N=3; rst asserted for one cycle at cycle 8.
  - At cycle 9: dout=0, busy=0, no done.
  - A new start at cycle 12 with H=1, L=1, N=1 gives a clean pulse at cycle 13 and done at cycle 15.
